wrr_arbiter: RTL and testbench



---
 rtl/wrr_arbiter.sv | 136 +++++++++++++
 tb/tb_wrr_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: N:1 weighted round-robin arbiter with per-port burst hold.
// Define WRR_ARB_GRANT_IDX_EN to add the binary grant_idx output.
module wrr_arbiter #(
    parameter  int PORT   = 4,
    parameter  int WEIGHT = 4,
    localparam int IDX    = $clog2(PORT)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   stall,
    input  logic [PORT-1:0]        req,
    input  logic [PORT*WEIGHT-1:0] weight,
    input  logic                   ack,
    output logic [PORT-1:0]        granto,
`ifdef WRR_ARB_GRANT_IDX_EN
    output logic [IDX-1:0]         grant_idx,
`endif
    output logic                   grant_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            busy_q, busy_d;
    logic [IDX-1:0]    owner_q, owner_d;
    logic [IDX-1:0]    ptr_q, ptr_d;
    logic [WEIGHT-1:0] cnt_q, cnt_d;

    logic [IDX-1:0]    win_idx;
    logic              win_found;
    logic [WEIGHT-1:0] win_w;
    logic [WEIGHT-1:0] eff_w;
    logic [IDX-1:0]    sel_idx;
    logic              sel_vld;

    function automatic logic [IDX-1:0] next_port(input logic [IDX-1:0] p);
        return (p == IDX'(PORT - 1)) ? '0 : p + IDX'(1);
    endfunction

    // Rotating-priority search starting at the pointer, wrapping at PORT-1.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < PORT; k++) begin
            j = int'(ptr_q) + k;
            if (j >= PORT) j = j - PORT;
            if (!win_found && req[IDX'(j)]) begin
                win_found = 1'b1;
                win_idx   = IDX'(j);
            end
        end
    end

    // Weight of the idle-mode winner; zero is treated as a single beat.
    always_comb begin
        win_w = '0;
        for (int i = 0; i < PORT; i++) begin
            if (IDX'(i) == win_idx) win_w = weight[i*WEIGHT +: WEIGHT];
        end
        eff_w = (win_w == '0) ? WEIGHT'(1) : win_w;
    end

    // Burst owner holds the grant exclusively; otherwise the search winner.
    always_comb begin
        sel_idx = win_idx;
        sel_vld = win_found;
        if (busy_q == BURST) begin
            sel_idx = owner_q;
            sel_vld = req[owner_q];
        end
    end

    assign grant_valid = sel_vld & ~stall & reset_n;
    assign granto      = grant_valid ? (PORT'(1) << sel_idx) : '0;

`ifdef WRR_ARB_GRANT_IDX_EN
    assign grant_idx = grant_valid ? sel_idx : '0;
`endif

    // Next-state: burst start, beat counting, forfeit and pointer rotation.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (!stall) begin
            unique case (busy_q)
                IDLE: begin
                    if (ack && win_found) begin
                        if (eff_w == WEIGHT'(1)) begin
                            ptr_d = next_port(win_idx);
                        end else begin
                            busy_d  = BURST;
                            owner_d = win_idx;
                            cnt_d   = eff_w - WEIGHT'(1);
                        end
                    end
                end
                BURST: begin
                    if (!req[owner_q]) begin
                        busy_d = IDLE;
                        ptr_d  = next_port(owner_q);
                    end else if (ack) begin
                        if (cnt_q == WEIGHT'(1)) begin
                            busy_d = IDLE;
                            ptr_d  = next_port(owner_q);
                        end else begin
                            cnt_d = cnt_q - WEIGHT'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: directed and random checks of a 4-port and a 3-port
// arbiter against a queue-free behavioural credit model.
module tb_wrr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        ack = 1'b0;
    logic [3:0]  req4 = '0;
    logic [2:0]  req3 = '0;
    logic [15:0] w4 = '0;
    logic [11:0] w3 = '0;
    logic [3:0]  granto4;
    logic [2:0]  granto3;
    logic        gv4, gv3;
`ifdef WRR_ARB_GRANT_IDX_EN
    logic [1:0]  gidx4, gidx3;
`endif

    int n_chk = 0;
    int n_fail = 0;

    int m_left[2];
    int m_owner[2];
    int m_ptr[2];

    typedef struct {
        int r4, r3, st, ak, rs, e4, e3;
    } step_t;
    step_t dq[$];

    always #5 clk = ~clk;

    wrr_arbiter #(.PORT(4), .WEIGHT(4)) u4 (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .req(req4), .weight(w4), .ack(ack),
        .granto(granto4),
`ifdef WRR_ARB_GRANT_IDX_EN
        .grant_idx(gidx4),
`endif
        .grant_valid(gv4)
    );

    wrr_arbiter #(.PORT(3), .WEIGHT(4)) u3 (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .req(req3), .weight(w3), .ack(ack),
        .granto(granto3),
`ifdef WRR_ARB_GRANT_IDX_EN
        .grant_idx(gidx3),
`endif
        .grant_valid(gv3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Port the model says is granted now, or -1 for none.
    function automatic int exp_win(int i, int np, logic [3:0] rq);
        if (!reset_n || stall) return -1;
        if (m_left[i] > 0) return rq[m_owner[i]] ? m_owner[i] : -1;
        for (int k = 0; k < np; k++)
            if (rq[(m_ptr[i] + k) % np]) return (m_ptr[i] + k) % np;
        return -1;
    endfunction

    task automatic m_update(int i, int np, logic [3:0] rq, logic [15:0] wt);
        int g, w;
        if (!reset_n) begin
            m_left[i] = 0; m_owner[i] = 0; m_ptr[i] = 0;
            return;
        end
        if (stall) return;
        g = exp_win(i, np, rq);
        if (m_left[i] > 0) begin
            if (!rq[m_owner[i]]) begin
                m_left[i] = 0;
                m_ptr[i] = (m_owner[i] + 1) % np;
            end else if (ack) begin
                m_left[i]--;
                if (m_left[i] == 0) m_ptr[i] = (m_owner[i] + 1) % np;
            end
        end else if (g >= 0 && ack) begin
            w = int'(wt[g*4 +: 4]);
            if (w == 0) w = 1;
            if (w == 1) m_ptr[i] = (g + 1) % np;
            else begin
                m_owner[i] = g;
                m_left[i] = w - 1;
            end
        end
    endtask

    // Called at negedge with inputs driven; checks, then advances one clock.
    task automatic cycle(int e4, int e3);
        int g4, g3;
        #1;
        g4 = exp_win(0, 4, req4);
        g3 = exp_win(1, 3, {1'b0, req3});
        chk("gnt4", granto4, (g4 < 0) ? 0 : (1 << g4));
        chk("vld4", gv4, g4 >= 0);
        chk("gnt3", granto3, (g3 < 0) ? 0 : (1 << g3));
        chk("vld3", gv3, g3 >= 0);
`ifdef WRR_ARB_GRANT_IDX_EN
        chk("idx4", gidx4, (g4 < 0) ? 0 : g4);
        chk("idx3", gidx3, (g3 < 0) ? 0 : g3);
`endif
        if (e4 >= 0) chk("dir4", granto4, e4);
        if (e3 >= 0) chk("dir3", granto3, e3);
        @(posedge clk);
        m_update(0, 4, req4, w4);
        m_update(1, 3, {1'b0, req3}, {4'b0, w3});
        @(negedge clk);
    endtask

    task automatic add(int r4, int r3, int st, int ak, int rs,
                       int e4, int e3);
        step_t s;
        s.r4 = r4; s.r3 = r3; s.st = st; s.ak = ak;
        s.rs = rs; s.e4 = e4; s.e3 = e3;
        dq.push_back(s);
    endtask

    task automatic run_dir();
        for (int s = 0; s < dq.size(); s++) begin
            req4    = 4'(dq[s].r4);
            req3    = 3'(dq[s].r3);
            stall   = dq[s].st != 0;
            ack     = dq[s].ak != 0;
            reset_n = dq[s].rs == 0;
            cycle(dq[s].e4, dq[s].e3);
        end
        reset_n = 1'b1;
        dq.delete();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_owner[i] = 0; m_ptr[i] = 0;
        end
        @(negedge clk);

        // plain rotation, reset holds grant low with all requests up
        w4 = 16'h1111;
        add(15, 7, 0, 1, 1, 0, 0);
        add(15, 0, 0, 1, 0, 1, -1);
        add(15, 0, 0, 1, 0, 2, -1);
        add(15, 0, 0, 1, 0, 4, -1);
        add(15, 0, 0, 1, 0, 8, -1);
        add(15, 0, 0, 1, 0, 1, -1);
        run_dir();

        // 3:1 share
        w4 = 16'h1113;
        add(3, 0, 0, 1, 1, 0, -1);
        add(3, 0, 0, 1, 0, 1, -1);
        add(3, 0, 0, 1, 0, 1, -1);
        add(3, 0, 0, 1, 0, 1, -1);
        add(3, 0, 0, 1, 0, 2, -1);
        add(3, 0, 0, 1, 0, 1, -1);
        add(3, 0, 0, 1, 0, 1, -1);
        add(3, 0, 0, 1, 0, 1, -1);
        run_dir();

        // forfeit bubble, then rotation past port 0
        w4 = 16'h1114;
        add(5, 0, 0, 1, 1, 0, -1);
        add(5, 0, 0, 1, 0, 1, -1);
        add(5, 0, 0, 1, 0, 1, -1);
        add(4, 0, 0, 1, 0, 0, -1);
        add(5, 0, 0, 1, 0, 4, -1);
        run_dir();

        // stall mid-burst keeps the remaining count
        w4 = 16'h1151;
        add(2, 0, 0, 1, 1, 0, -1);
        add(2, 0, 0, 1, 0, 2, -1);
        add(2, 0, 0, 1, 0, 2, -1);
        add(2, 0, 1, 1, 0, 0, -1);
        add(2, 0, 1, 1, 0, 0, -1);
        add(2, 0, 1, 1, 0, 0, -1);
        add(2, 0, 0, 1, 0, 2, -1);
        add(2, 0, 0, 1, 0, 2, -1);
        add(2, 0, 0, 1, 0, 2, -1);
        add(4, 0, 0, 1, 0, 4, -1);
        run_dir();

        // zero weights, ack toggling
        w4 = 16'h0000;
        add(9, 0, 0, 1, 1, 0, -1);
        add(9, 0, 0, 1, 0, 1, -1);
        add(9, 0, 0, 0, 0, 8, -1);
        add(9, 0, 0, 1, 0, 8, -1);
        add(9, 0, 0, 0, 0, 1, -1);
        add(9, 0, 0, 1, 0, 1, -1);
        run_dir();

        // three ports: burst interrupted by reset, then rotation 0,1,2,0
        w3 = 12'h113;
        add(0, 7, 0, 1, 1, -1, 0);
        add(0, 7, 0, 1, 0, -1, 1);
        add(0, 7, 0, 1, 0, -1, 1);
        run_dir();
        w3 = 12'h111;
        add(0, 7, 0, 1, 1, -1, 0);
        add(0, 7, 0, 1, 0, -1, 1);
        add(0, 7, 0, 1, 0, -1, 2);
        add(0, 7, 0, 1, 0, -1, 4);
        add(0, 7, 0, 1, 0, -1, 1);
        run_dir();

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset_n = $urandom_range(0, 199) != 0;
            stall   = $urandom_range(0, 9) == 0;
            ack     = $urandom_range(0, 9) < 7;
            req4    = 4'($urandom) | 4'($urandom);
            req3    = 3'($urandom) | 3'($urandom);
            if ($urandom_range(0, 15) == 0) w4 = 16'($urandom);
            if ($urandom_range(0, 15) == 0) w3 = 12'($urandom);
            cycle(-1, -1);
        end
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
